// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Common-data-bus arbiter for the Tomasulo back end. Each cycle it picks at
//   most one completed result from NUM_FU functional-unit channels and
//   broadcasts it on a registered CDB. The winning unit gets a one-cycle read
//   pulse. The arbitration policy is round-robin (RR_EN=1) or fixed priority
//   (RR_EN=0, lowest index wins). A flush discards every pending result at
//   once. A 32-bit counter tracks the number of broadcasts.
//
// Ports
//   clk_in          system clock, rising edge
//   rst_in          asynchronous active-low reset
//   flush_in        misprediction flush from the ROB
//   fu_valid_in     per-channel "result held" flags
//   fu_rob_ix_in    per-channel ROB index, channel k at [k*ROB_IX_W +: ROB_IX_W]
//   fu_data_in      per-channel result, channel k at [k*DATA_W +: DATA_W]
//   fu_read_out     registered one-cycle acknowledge per channel
//   cdb_valid_out   broadcast valid
//   cdb_rob_ix_out  ROB index of the broadcast result
//   cdb_value_out   broadcast result value
//   cdb_count_out   broadcasts since reset, wraps at 2^32
module cdb_arbiter #(
  parameter int NUM_FU   = 4,
  parameter int ROB_IX_W = 3,
  parameter int DATA_W   = 32,
  parameter bit RR_EN    = 1'b1
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         flush_in,
  input  logic [NUM_FU-1:0]            fu_valid_in,
  input  logic [NUM_FU*ROB_IX_W-1:0]   fu_rob_ix_in,
  input  logic [NUM_FU*DATA_W-1:0]     fu_data_in,
  output logic [NUM_FU-1:0]            fu_read_out,
  output logic                         cdb_valid_out,
  output logic [ROB_IX_W-1:0]          cdb_rob_ix_out,
  output logic [DATA_W-1:0]            cdb_value_out,
  output logic [31:0]                  cdb_count_out
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    ptr_next;
  logic [PTR_W-1:0]    grant_ix;
  logic                grant_valid;
  logic [NUM_FU-1:0]   elig;
  logic [NUM_FU-1:0]   grant_onehot;
  logic [ROB_IX_W-1:0] sel_rob;
  logic [DATA_W-1:0]   sel_data;
  int                  search_ix;

  // A channel acknowledged last cycle may still show valid this cycle.
  // Masking it keeps the same result from being broadcast twice.
  assign elig = fu_valid_in & ~fu_read_out;

  // The search order starts at rr_ptr (or at 0 for fixed priority) and wraps.
  // Walking the offsets from last to first lets the earliest eligible channel
  // in search order be the final assignment.
  always_comb begin
    grant_valid = 1'b0;
    grant_ix    = '0;
    search_ix   = 0;
    for (int off = NUM_FU - 1; off >= 0; off--) begin
      search_ix = (RR_EN ? int'(rr_ptr) : 0) + off;
      if (search_ix >= NUM_FU) search_ix = search_ix - NUM_FU;
      if (elig[PTR_W'(search_ix)]) begin
        grant_valid = 1'b1;
        grant_ix    = PTR_W'(search_ix);
      end
    end
  end

  // Select the winner's payload and build its one-hot acknowledge.
  always_comb begin
    sel_rob      = '0;
    sel_data     = '0;
    grant_onehot = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (grant_valid && (grant_ix == PTR_W'(k))) begin
        sel_rob         = fu_rob_ix_in[k*ROB_IX_W +: ROB_IX_W];
        sel_data        = fu_data_in[k*DATA_W +: DATA_W];
        grant_onehot[k] = 1'b1;
      end
    end
  end

  // For a non-power-of-2 NUM_FU the pointer needs an explicit wrap.
  assign ptr_next = (grant_ix == PTR_W'(NUM_FU - 1)) ? '0 : grant_ix + 1'b1;

  // Output and pointer registers. A flush acknowledges every eligible channel
  // so the units drop stale results. It makes no broadcast and leaves the
  // pointer and the counter unchanged. When there is no grant the data
  // registers keep their last value.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fu_read_out    <= '0;
      cdb_valid_out  <= 1'b0;
      cdb_rob_ix_out <= '0;
      cdb_value_out  <= '0;
      cdb_count_out  <= '0;
      rr_ptr         <= '0;
    end else if (flush_in) begin
      fu_read_out   <= elig;
      cdb_valid_out <= 1'b0;
    end else if (grant_valid) begin
      fu_read_out    <= grant_onehot;
      cdb_valid_out  <= 1'b1;
      cdb_rob_ix_out <= sel_rob;
      cdb_value_out  <= sel_data;
      cdb_count_out  <= cdb_count_out + 32'd1;
      if (RR_EN) rr_ptr <= ptr_next;
    end else begin
      fu_read_out   <= '0;
      cdb_valid_out <= 1'b0;
    end
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Parametrised common-data-bus arbiter for the Tomasulo back end. It collects completed results from NUM_FU functional-unit channels (ALU, multiplier, load buffer, branch ALU, …), grants at most one per cycle, and broadcasts the winner on a registered CDB to the ROB and every reservation station. It acknowledges the winning unit with a one-cycle read pulse. It supports fixed-priority or round-robin policy, flush-driven drain of stale results, and a broadcast counter.

## Interface
- NUM_FU, 4: number of functional-unit channels (2..8).
- ROB_IX_W, 3: ROB index width.
- DATA_W, 32: result width.
- RR_EN, 1: 1 selects round-robin; 0 selects fixed priority (lowest index wins).
- clk_in  input  1  system clock; all state updates on the rising edge.
- rst_in  input  1  reset; asynchronous, active-low.
- flush_in  input  1  misprediction flush from the ROB.
- fu_valid_in  input  NUM_FU  bit k high: channel k holds a result; held until acknowledged.
- fu_rob_ix_in  input  NUM_FU*ROB_IX_W  channel k occupies bits [k*ROB_IX_W +: ROB_IX_W].
- fu_data_in  input  NUM_FU*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- fu_read_out  output  NUM_FU  one-cycle acknowledge per channel (registered).
- cdb_valid_out  output  1  broadcast valid this cycle.
- cdb_rob_ix_out  output  ROB_IX_W  ROB index of the broadcast result.
- cdb_value_out  output  DATA_W  broadcast result.
- cdb_count_out  output  32  total broadcasts since reset; wraps at 2^32.

## Operation
- Eligible set: elig[k] = fu_valid_in[k] & ~fu_read_out[k]. The mask covers the cycle in which a unit has been acknowledged but has not yet dropped valid, so no result is broadcast twice.
- Grant is combinational on elig.
  - RR_EN=0: the lowest set index wins.
  - RR_EN=1: search starts at rr_ptr and runs upward, wrapping from NUM_FU-1 to 0. The first eligible channel wins.
- rr_ptr: ceil(log2 NUM_FU) bits, reset 0. On a grant to channel g, rr_ptr becomes (g+1) mod NUM_FU, with an explicit wrap for non-power-of-2 NUM_FU. With no grant, rr_ptr holds. RR_EN=0 never updates rr_ptr.
- On a grant to channel g (flush_in low):
  - cdb_valid_out, cdb_rob_ix_out and cdb_value_out are registered from channel g.
  - fu_read_out becomes one-hot g for one cycle.
  - cdb_count_out increments by 1.
- With no eligible channel: cdb_valid_out goes to 0, fu_read_out to 0, and the data registers hold their last value.
- Flush (flush_in high):
  - No grant is made and no broadcast occurs: cdb_valid_out goes to 0 next cycle.
  - fu_read_out is set to elig, discarding every pending result at once.
  - rr_ptr and cdb_count_out hold.
  - A broadcast already in the output register on the flush cycle still completes (it is visible that cycle); the ROB is responsible for ignoring it.
- Reset (rst_in low, any time, including mid-broadcast):
  - fu_read_out=0, cdb_valid_out=0, cdb_rob_ix_out=0, cdb_value_out=0, cdb_count_out=0, rr_ptr=0, all asynchronously.
  - After rst_in rises, the first grant can occur on the first clock edge.

## Timing
- Latency:
  - Result present in cycle t (eligible, winning) → cdb_valid_out high in cycle t+1.
  - fu_read_out[g] is high in t+1.
  - The unit drops valid at the t+1 edge, or presents a new result that becomes eligible in t+2.
- Throughput:
  - One broadcast per cycle when at least two channels are pending.
  - A single channel streaming alone gets one broadcast every two cycles, because of the acknowledge mask.
- Fairness with RR_EN=1: a continuously-valid channel waits at most NUM_FU-1 grants.
- flush_in takes effect at the same edge: a grant that would otherwise be taken on the flush cycle is suppressed.
- No combinational path from any input to any output.

## Test plan
- Reset values: drive rst_in=0 mid-broadcast (cdb_valid_out=1, cdb_count_out=5) → all outputs 0 immediately, without waiting for a clock edge.
- Single channel, RR_EN=1: fu_valid_in=4'b0010, rob_ix[1]=3, data[1]=32'h0000_00AA from cycle 0 → cdb_valid_out=1, rob_ix 3, value 0xAA in cycle 1; fu_read_out=4'b0010 in cycle 1; no second broadcast in cycle 2 even though valid is still high.
- Round-robin rotation: all four channels held valid, each re-asserting a new result after its acknowledge → winners 0,1,2,3,0,… on consecutive cycles; cdb_count_out=8 after 8 cycles.
- Fixed priority, RR_EN=0: channels 0 and 2 continuously valid → channel 0 wins every eligible cycle; channel 2 is granted only in cycles where channel 0 is masked (alternating 0,2,0,2).
- Flush drain: channels 1 and 3 valid, flush_in high for one cycle → next cycle fu_read_out=4'b1010, cdb_valid_out=0, cdb_count_out unchanged.
- Non-power-of-2 wrap, NUM_FU=3: grant to channel 2 → rr_ptr=0; next search picks channel 0 over channel 1 when both are valid.
